seq_game_engine: RTL

//  Parametrised successor to the single-FSM game controller. Runs N_GAMES input-sequence games of N_STEPS steps each, from a pattern ROM.

---
 rtl/seq_game_pkg.sv | 68 ++++++
 rtl/seq_pattern_rom.sv | 26 ++
 rtl/seq_game_engine.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_game_pkg.sv
// Shared types and constant tables for the sequence game engine.
// Holds the FSM state enum, the quiz answer table and the default pattern/mask tables.
package seq_game_pkg;

    typedef enum logic [2:0] {
        INI  = 3'd0,
        IDLE = 3'd1,
        PLAY = 3'd2,
        DONE = 3'd3,
        QUIZ = 3'd4,
        WIN  = 3'd5,
        LOSE = 3'd6
    } state_t;

    localparam int unsigned PAT_W    = 9;
    localparam int unsigned BTNC_BIT = 4;
    localparam int unsigned ANS_W    = 4;

    // Answer for quiz n (1-based) sits at index n-1; the first entry is the MSB nibble.
    localparam logic [3*ANS_W-1:0] QUIZ_ANS = {4'h1, 4'h2, 4'h8};

    function automatic logic [ANS_W-1:0] quiz_ans(input int unsigned idx);
        case (idx)
            32'd0:   return QUIZ_ANS[11:8];
            32'd1:   return QUIZ_ANS[7:4];
            default: return QUIZ_ANS[3:0];
        endcase
    endfunction

    // Step patterns; the last step of every game is the all-released step.
    function automatic logic [PAT_W-1:0] pat_entry(input int unsigned g, input int unsigned s);
        logic [PAT_W-1:0] p;
        p = '0;
        case (g)
            32'd0: case (s)
                32'd0:   p = 9'h001;
                32'd1:   p = 9'h003;
                32'd2:   p = 9'h007;
                default: p = 9'h000;
            endcase
            32'd1: case (s)
                32'd0:   p = 9'h008;
                32'd1:   p = 9'h00C;
                32'd2:   p = 9'h00E;
                default: p = 9'h000;
            endcase
            32'd2: case (s)
                32'd0:   p = 9'h020;
                32'd1:   p = 9'h060;
                32'd2:   p = 9'h0E0;
                default: p = 9'h000;
            endcase
            default: p = '0;
        endcase
        return p;
    endfunction

    // Games 0/1 watch the switches, game 2 watches BtnL/BtnR/BtnU/BtnD.
    function automatic logic [PAT_W-1:0] mask_entry(input int unsigned g);
        case (g)
            32'd0:   return 9'h00F;
            32'd1:   return 9'h00F;
            32'd2:   return 9'h1E0;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/seq_pattern_rom.sv
// Combinational pattern ROM: pattern and mask for (game, step), plus the
// previous step's pattern (all-zero for step 0) used for mismatch detection.
module seq_pattern_rom
    import seq_game_pkg::*;
#(
    parameter int unsigned IN_W = 9,
    parameter int unsigned G_W  = 2,
    parameter int unsigned S_W  = 3
) (
    input  logic [G_W-1:0]  g,
    input  logic [S_W-1:0]  s,
    output logic [IN_W-1:0] pat,
    output logic [IN_W-1:0] mask,
    output logic [IN_W-1:0] pat_prev
);

    always_comb begin
        pat      = IN_W'(pat_entry(32'(g), 32'(s)));
        mask     = IN_W'(mask_entry(32'(g)));
        pat_prev = '0;
        if (s != '0) begin
            pat_prev = IN_W'(pat_entry(32'(g), 32'(s) - 32'd1));
        end
    end

endmodule

// File: rtl/seq_game_engine.sv
// Sequence game controller: pattern games, minute clock, professor quizzes, lives.
// Optional FPSR_PAUSE_EN adds a pause input that freezes all state and ignores minute_tick.
module seq_game_engine
    import seq_game_pkg::*;
#(
    parameter int unsigned IN_W        = 9,
    parameter int unsigned N_GAMES     = 3,
    parameter int unsigned N_STEPS     = 4,
    parameter int unsigned MAX_MIN     = 120,
    parameter int unsigned QUIZ_PERIOD = 15,
    parameter int unsigned QUIZ_WINDOW = 3,
    parameter int unsigned LIVES_INIT  = 3
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             start,
    input  logic                             ack,
    input  logic                             minute_tick,
    input  logic [IN_W-1:0]                  in_vec,
`ifdef FPSR_PAUSE_EN
    input  logic                             pause,
`endif
    output logic [2:0]                       state_o,
    output logic [$clog2(N_GAMES+1)-1:0]     game_idx,
    output logic [$clog2(N_STEPS+1)-1:0]     step_idx,
    output logic [2:0]                       lives,
    output logic [7:0]                       minutes,
    output logic [3:0]                       quiz_cnt,
    output logic                             professor,
    output logic                             win,
    output logic                             lose
);

    localparam int unsigned G_W = $clog2(N_GAMES+1);
    localparam int unsigned S_W = $clog2(N_STEPS+1);

    state_t          state;
    state_t          nxt_c;
    logic [IN_W-1:0] in_prev;
    logic [8:0]      quiz_deadline;

    logic [IN_W-1:0] pat_c, mask_c, pat_prev_c, masked_c;
    logic            hold_c, changed_c, match_c, mismatch_c, btnc_rise_c;
    logic            tick_live_c, quiz_due_c, over_c, deadline_hit_c, ans_ok_c;
    logic            last_step_c, last_game_c, last_life_c;
    logic [7:0]      min_next_c;
    int unsigned     qi_c;

    logic load_c, lose_life_c, step_adv_c, step_clr_c, game_adv_c, quiz_enter_c;

`ifdef FPSR_PAUSE_EN
    assign hold_c = pause;
`else
    assign hold_c = 1'b0;
`endif

    seq_pattern_rom #(
        .IN_W (IN_W),
        .G_W  (G_W),
        .S_W  (S_W)
    ) u_rom (
        .g        (game_idx),
        .s        (step_idx),
        .pat      (pat_c),
        .mask     (mask_c),
        .pat_prev (pat_prev_c)
    );

    // Step and quiz input decode
    assign masked_c    = in_vec & mask_c;
    assign changed_c   = (in_vec != in_prev);
    assign match_c     = changed_c && (masked_c == (pat_c & mask_c));
    assign mismatch_c  = (masked_c != (pat_c & mask_c)) && (masked_c != (pat_prev_c & mask_c));
    assign btnc_rise_c = in_vec[BTNC_BIT] & ~in_prev[BTNC_BIT];
    assign last_step_c = (step_idx == S_W'(N_STEPS - 1));
    assign last_game_c = (game_idx == G_W'(N_GAMES - 1));
    assign last_life_c = (lives <= 3'd1);

    always_comb begin
        if (quiz_cnt >= 4'd3) begin
            qi_c = 32'd2;
        end else if (quiz_cnt == 4'd0) begin
            qi_c = 32'd0;
        end else begin
            qi_c = 32'(quiz_cnt) - 32'd1;
        end
    end

    assign ans_ok_c = (in_vec[ANS_W-1:0] == quiz_ans(qi_c));

    // Minute clock and quiz scheduling
    assign tick_live_c    = minute_tick && !(state inside {INI, WIN, LOSE});
    assign min_next_c     = (minutes == 8'hFF) ? minutes : minutes + 8'd1;
    assign quiz_due_c     = tick_live_c && (state != QUIZ) &&
                            ((32'(min_next_c) % QUIZ_PERIOD) == 32'd0);
    assign over_c         = (32'(minutes) >= MAX_MIN);
    assign deadline_hit_c = (9'(minutes) == quiz_deadline);

    // Next state and per-cycle actions, highest priority first within each state
    always_comb begin
        nxt_c        = state;
        load_c       = 1'b0;
        lose_life_c  = 1'b0;
        step_adv_c   = 1'b0;
        step_clr_c   = 1'b0;
        game_adv_c   = 1'b0;
        quiz_enter_c = 1'b0;
        case (state)
            INI: begin
                if (start) begin
                    nxt_c  = IDLE;
                    load_c = 1'b1;
                end
            end
            IDLE: begin
                if (lives == 3'd0 || over_c) begin
                    nxt_c = LOSE;
                end else if (professor) begin
                    nxt_c        = QUIZ;
                    quiz_enter_c = 1'b1;
                end else if (btnc_rise_c) begin
                    nxt_c = PLAY;
                end
            end
            PLAY: begin
                if (lives == 3'd0 || over_c) begin
                    nxt_c = LOSE;
                end else if (professor) begin
                    nxt_c        = QUIZ;
                    quiz_enter_c = 1'b1;
                end else if (match_c) begin
                    step_adv_c = 1'b1;
                    if (last_step_c) begin
                        nxt_c = DONE;
                    end
                end else if (mismatch_c) begin
                    lose_life_c = 1'b1;
                    step_clr_c  = 1'b1;
                    nxt_c       = last_life_c ? LOSE : IDLE;
                end
            end
            DONE: begin
                game_adv_c = 1'b1;
                step_clr_c = 1'b1;
                nxt_c      = last_game_c ? WIN : IDLE;
            end
            QUIZ: begin
                if (lives == 3'd0) begin
                    nxt_c = LOSE;
                end else if (btnc_rise_c && ans_ok_c) begin
                    nxt_c      = IDLE;
                    step_clr_c = 1'b1;
                end else if (btnc_rise_c || deadline_hit_c) begin
                    lose_life_c = 1'b1;
                    step_clr_c  = 1'b1;
                    nxt_c       = last_life_c ? LOSE : IDLE;
                end
            end
            WIN, LOSE: begin
                if (ack) begin
                    nxt_c = INI;
                end
            end
            default: nxt_c = INI;
        endcase
    end

    // State register and all registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= INI;
            in_prev       <= '0;
            quiz_deadline <= '0;
            game_idx      <= '0;
            step_idx      <= '0;
            lives         <= '0;
            minutes       <= '0;
            quiz_cnt      <= '0;
            professor     <= 1'b0;
            win           <= 1'b0;
            lose          <= 1'b0;
        end else if (!hold_c) begin
            state   <= nxt_c;
            win     <= (nxt_c == WIN);
            lose    <= (nxt_c == LOSE);
            in_prev <= in_vec;
            if (load_c) begin
                lives         <= 3'(LIVES_INIT);
                minutes       <= '0;
                quiz_cnt      <= '0;
                professor     <= 1'b0;
                game_idx      <= '0;
                step_idx      <= '0;
                quiz_deadline <= '0;
            end else begin
                if (tick_live_c) begin
                    minutes <= min_next_c;
                end
                if (quiz_due_c) begin
                    if (quiz_cnt != 4'hF) begin
                        quiz_cnt <= quiz_cnt + 4'd1;
                    end
                    quiz_deadline <= 9'(32'(min_next_c) + QUIZ_WINDOW);
                end
                if (quiz_enter_c) begin
                    professor <= 1'b0;
                end else if (quiz_due_c) begin
                    professor <= 1'b1;
                end
                if (lose_life_c && lives != 3'd0) begin
                    lives <= lives - 3'd1;
                end
                if (step_clr_c) begin
                    step_idx <= '0;
                end else if (step_adv_c) begin
                    step_idx <= step_idx + S_W'(1);
                end
                if (game_adv_c) begin
                    game_idx <= game_idx + G_W'(1);
                end
            end
        end
    end

    assign state_o = state;

endmodule
